iq_decim_accum: RTL

//  Integrate-and-dump decimator directly downstream of the I/Q sample FIFO.
//  - Pulls complex samples from the FIFO's show-ahead read port.
//  - Sums DECIM consecutive I and Q samples and emits their mean, 1 output per DECIM inputs.
//  - Output leaves on a valid/ready handshake to the next datapath stage.

---
 rtl/iq_decim_accum_if.sv | 25 ++
 rtl/iq_decim_accum.sv | 106 ++++++++++
 2 files changed

// File: rtl/iq_decim_accum_if.sv
// I/Q decimator port bundle: FIFO show-ahead read side plus the
// valid/ready output side of iq_decim_accum.
// master = the decimator, slave = its environment (FIFO + downstream).
interface iq_decim_accum_if #(
  parameter int IN_W = 24
);
  logic            empty;
  logic [IN_W-1:0] SampI_datapath;
  logic [IN_W-1:0] SampQ_datapath;
  logic            PullOut;
  logic            out_ready;
  logic            PushOut;
  logic [IN_W-1:0] SampI_out;
  logic [IN_W-1:0] SampQ_out;

  modport master (
    input  empty, SampI_datapath, SampQ_datapath, out_ready,
    output PullOut, PushOut, SampI_out, SampQ_out
  );

  modport slave (
    output empty, SampI_datapath, SampQ_datapath, out_ready,
    input  PullOut, PushOut, SampI_out, SampQ_out
  );
endinterface

// File: rtl/iq_decim_accum.sv
// Integrate-and-dump I/Q decimator.
// Pulls DECIM complex samples from a show-ahead FIFO, sums them and emits the
// mean on a valid/ready output. The final pull of a block only stalls when the
// previous result is still waiting for downstream.
// Optional feature macro: IQ_DECIM_ROUND_EN
//   defined   -> round half-up before the divide-by-DECIM shift
//   undefined -> truncate toward -inf
module iq_decim_accum #(
  parameter int IN_W  = 24,
  parameter int DECIM = 4
) (
  input  logic             clk,
  input  logic             reset,
  iq_decim_accum_if.master bus
);

  localparam int SHIFT = $clog2(DECIM);
  localparam int ACC_W = IN_W + SHIFT;
  localparam logic [SHIFT-1:0] LAST_CNT = SHIFT'(DECIM - 1);
  localparam logic [SHIFT-1:0] CNT_ONE  = {{(SHIFT-1){1'b0}}, 1'b1};
`ifdef IQ_DECIM_ROUND_EN
  localparam logic [ACC_W:0] ROUND_C = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
`endif

  // Sign-extend a sample to accumulator width.
  function automatic logic [ACC_W-1:0] sext(input logic [IN_W-1:0] x);
    return {{SHIFT{x[IN_W-1]}}, x};
  endfunction

  // Divide a block sum by DECIM. One guard bit keeps the rounding add from
  // wrapping when the sum sits at the positive maximum.
  function automatic logic [IN_W-1:0] scaleDown(input logic [ACC_W-1:0] sum);
    logic signed [ACC_W:0] wide;
    wide = $signed({sum[ACC_W-1], sum});
`ifdef IQ_DECIM_ROUND_EN
    wide = wide + $signed(ROUND_C);
`endif
    wide = wide >>> SHIFT;
    return wide[IN_W-1:0];
  endfunction

  logic [ACC_W-1:0] accI_r, accQ_r, accI_s, accQ_s;
  logic [SHIFT-1:0] cnt_r, cnt_s;
  logic             pushOut_r, pushOut_s;
  logic [IN_W-1:0]  outI_r, outQ_r, outI_s, outQ_s;
  logic             last_s, pull_s;
  logic [ACC_W-1:0] sumI_s, sumQ_s;

  assign last_s = (cnt_r == LAST_CNT);
  // Only the closing pull of a block has to wait for a blocked output.
  assign pull_s = ~reset & ~bus.empty & ~(last_s & pushOut_r & ~bus.out_ready);
  assign sumI_s = accI_r + sext(bus.SampI_datapath);
  assign sumQ_s = accQ_r + sext(bus.SampQ_datapath);

  assign bus.PullOut   = pull_s;
  assign bus.PushOut   = pushOut_r;
  assign bus.SampI_out = outI_r;
  assign bus.SampQ_out = outQ_r;

  // Next-state: accumulate on a pull, dump the mean on the closing pull.
  always_comb begin
    accI_s    = accI_r;
    accQ_s    = accQ_r;
    cnt_s     = cnt_r;
    outI_s    = outI_r;
    outQ_s    = outQ_r;
    pushOut_s = pushOut_r & ~bus.out_ready;
    if (pull_s) begin
      if (last_s) begin
        accI_s    = '0;
        accQ_s    = '0;
        cnt_s     = '0;
        outI_s    = scaleDown(sumI_s);
        outQ_s    = scaleDown(sumQ_s);
        pushOut_s = 1'b1;
      end else begin
        accI_s = sumI_s;
        accQ_s = sumQ_s;
        cnt_s  = cnt_r + CNT_ONE;
      end
    end else begin
      accI_s = accI_r;
      accQ_s = accQ_r;
    end
  end

  // State and registered outputs; reset discards partial sums and pending output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accI_r    <= '0;
      accQ_r    <= '0;
      cnt_r     <= '0;
      pushOut_r <= 1'b0;
      outI_r    <= '0;
      outQ_r    <= '0;
    end else begin
      accI_r    <= accI_s;
      accQ_r    <= accQ_s;
      cnt_r     <= cnt_s;
      pushOut_r <= pushOut_s;
      outI_r    <= outI_s;
      outQ_r    <= outQ_s;
    end
  end

endmodule
